vcve2_vrf_seq: RTL and testbench

VCVE2_VRF_SEQ -- requirements
Module: vcve2_vrf_seq

---
 rtl/vcve2_pkg.sv | 29 ++
 rtl/vcve2_vrf_seq.sv | 208 ++++++++++++++++++++
 tb/tb_vcve2_vrf_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vcve2_pkg.sv
// Shared types and constants for the VRF sequencer.
// Contents:
//   VrfWordWidth - width of one vector-register word
//   vrf_state_e  - sequencer FSM states
//   word_entry() - first state of a word, based on which operands are read
package vcve2_pkg;

  localparam int unsigned VrfWordWidth = 32;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StRs1Req,
    StRs1Wait,
    StRs2Req,
    StRs2Wait,
    StExec,
    StRdReq,
    StDone
  } vrf_state_e;

  // A word starts at the first source it has to read, or at EXEC if none.
  function automatic vrf_state_e word_entry(input logic use_rs1, input logic use_rs2);
    if (use_rs1) return StRs1Req;
    if (use_rs2) return StRs2Req;
    return StExec;
  endfunction

endpackage

// File: rtl/vcve2_vrf_seq.sv
// Vector register file sequencer: walks NumWords 32-bit words of a vector
// instruction, reading vs1/vs2 from VRF memory, handing operands to the
// execute unit and writing the result back, while steering an external AGU.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   start_i, use_rs1_i/use_rs2_i instruction issue (sampled in IDLE only)
//   busy_o, done_o               status; done_o is a one-cycle pulse
//   agu_*_o                      AGU load / source select / increment
//   mem_*                        VRF memory request/grant/rvalid handshake
//   op_a_o, op_b_o, op_valid_o   operands to the execute unit
//   res_valid_i, res_i           execute result for the current word
//
// Optional feature (macro VCVE2_SLIDE_EN): adds slide_i, slide_up_i and
// slide_off_i. A slide skips vs1 reads and EXEC, copies each vs2 word
// straight to the write buffer and processes NumWords-slide_off_i words.
// The slide direction only matters to the AGU's addressing.
module vcve2_vrf_seq
  import vcve2_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumWords  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          use_rs1_i,
  input  logic                          use_rs2_i,
`ifdef VCVE2_SLIDE_EN
  input  logic                          slide_i,
  input  logic                          slide_up_i,
  input  logic [$clog2(NumWords):0]     slide_off_i,
`endif
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          agu_load_o,
  output logic                          agu_get_rs1_o,
  output logic                          agu_get_rs2_o,
  output logic                          agu_get_rd_o,
  output logic                          agu_incr_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [VrfWordWidth-1:0]       mem_rdata_i,
  output logic [VrfWordWidth-1:0]       mem_wdata_o,
  output logic [VrfWordWidth-1:0]       op_a_o,
  output logic [VrfWordWidth-1:0]       op_b_o,
  output logic                          op_valid_o,
  input  logic                          res_valid_i,
  input  logic [VrfWordWidth-1:0]       res_i
);

  localparam int unsigned CntW = $clog2(NumWords);
  localparam int unsigned OffW = CntW + 1;

  // AddrWidth only configures the AGU beside this block; reject nonsense here.
  if ((NumWords != 2 && NumWords != 4 && NumWords != 8) || AddrWidth == 0) begin : gen_param_check
    $error("vcve2_vrf_seq: NumWords must be 2, 4 or 8 and AddrWidth nonzero");
  end

  vrf_state_e              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [CntW-1:0]         last_q, last_d;
  logic                    use_rs1_q, use_rs1_d;
  logic                    use_rs2_q, use_rs2_d;
  logic [VrfWordWidth-1:0] op_a_q, op_a_d;
  logic [VrfWordWidth-1:0] op_b_q, op_b_d;
  logic [VrfWordWidth-1:0] wbuf_q, wbuf_d;
  logic                    slide_act;
  logic                    skip_act;

`ifdef VCVE2_SLIDE_EN
  logic            slide_q, slide_d;
  logic            skip_q, skip_d;
  logic [OffW-1:0] off_last;

  // Index of the last processed word; only meaningful when the offset is in range.
  assign off_last  = OffW'(NumWords - 1) - slide_off_i;
  assign slide_act = slide_q;
  assign skip_act  = skip_q;
`else
  assign slide_act = 1'b0;
  assign skip_act  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    use_rs1_d = use_rs1_q;
    use_rs2_d = use_rs2_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    wbuf_d    = wbuf_q;
`ifdef VCVE2_SLIDE_EN
    slide_d   = slide_q;
    skip_d    = skip_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StLoad;
          use_rs1_d = use_rs1_i;
          use_rs2_d = use_rs2_i;
          last_d    = CntW'(NumWords - 1);
`ifdef VCVE2_SLIDE_EN
          slide_d = slide_i;
          skip_d  = slide_i && (slide_off_i >= OffW'(NumWords));
          if (slide_i) begin
            // A slide is a pure vs2 -> vd copy.
            use_rs1_d = 1'b0;
            use_rs2_d = 1'b1;
            last_d    = off_last[CntW-1:0];
          end
`endif
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = skip_act ? StDone : word_entry(use_rs1_q, use_rs2_q);
      end
      StRs1Req: if (mem_gnt_i) state_d = StRs1Wait;
      StRs1Wait: begin
        if (mem_rvalid_i) begin
          op_a_d  = mem_rdata_i;
          state_d = use_rs2_q ? StRs2Req : StExec;
        end
      end
      StRs2Req: if (mem_gnt_i) state_d = StRs2Wait;
      StRs2Wait: begin
        if (mem_rvalid_i) begin
          if (slide_act) begin
            wbuf_d  = mem_rdata_i;
            state_d = StRdReq;
          end else begin
            op_b_d  = mem_rdata_i;
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (res_valid_i) begin
          wbuf_d  = res_i;
          state_d = StRdReq;
        end
      end
      StRdReq: begin
        // The write is complete at grant; a later rvalid is never waited for.
        if (mem_gnt_i) begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = (cnt_q == last_q) ? StDone : word_entry(use_rs1_q, use_rs2_q);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      wbuf_q    <= '0;
`ifdef VCVE2_SLIDE_EN
      slide_q   <= 1'b0;
      skip_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      use_rs1_q <= use_rs1_d;
      use_rs2_q <= use_rs2_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      wbuf_q    <= wbuf_d;
`ifdef VCVE2_SLIDE_EN
      slide_q   <= slide_d;
      skip_q    <= skip_d;
`endif
    end
  end

  // Controls decode from the registered state only, so an asynchronous reset
  // drops every output in the same cycle.
  always_comb begin
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StDone);
    agu_load_o    = (state_q == StLoad);
    agu_get_rs1_o = (state_q == StRs1Req) || (state_q == StRs1Wait);
    agu_get_rs2_o = (state_q == StRs2Req) || (state_q == StRs2Wait);
    agu_get_rd_o  = (state_q == StRdReq);
    mem_req_o     = (state_q == StRs1Req) || (state_q == StRs2Req) || (state_q == StRdReq);
    mem_we_o      = (state_q == StRdReq);
    agu_incr_o    = mem_req_o && mem_gnt_i;
    op_valid_o    = (state_q == StExec);
    op_a_o        = op_a_q;
    op_b_o        = op_b_q;
    mem_wdata_o   = wbuf_q;
  end

endmodule

// File: tb/tb_vcve2_vrf_seq.sv
module tb_vcve2_vrf_seq;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N);

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        use_rs1_i = 1'b0;
  logic        use_rs2_i = 1'b0;
`ifdef VCVE2_SLIDE_EN
  logic        slide_i = 1'b0;
  logic        slide_up_i = 1'b0;
  logic [CW:0] slide_off_i = '0;
`endif
  logic        busy_o, done_o, agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o;
  logic        agu_incr_o, mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, op_valid_o;
  logic        res_valid_i;
  logic [31:0] mem_rdata_i, mem_wdata_o, op_a_o, op_b_o, res_i;

  always #5 clk = ~clk;

  vcve2_vrf_seq #(.AddrWidth(32), .NumWords(N)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .use_rs1_i     (use_rs1_i),
    .use_rs2_i     (use_rs2_i),
`ifdef VCVE2_SLIDE_EN
    .slide_i       (slide_i),
    .slide_up_i    (slide_up_i),
    .slide_off_i   (slide_off_i),
`endif
    .busy_o        (busy_o),
    .done_o        (done_o),
    .agu_load_o    (agu_load_o),
    .agu_get_rs1_o (agu_get_rs1_o),
    .agu_get_rs2_o (agu_get_rs2_o),
    .agu_get_rd_o  (agu_get_rd_o),
    .agu_incr_o    (agu_incr_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_wdata_o   (mem_wdata_o),
    .op_a_o        (op_a_o),
    .op_b_o        (op_b_o),
    .op_valid_o    (op_valid_o),
    .res_valid_i   (res_valid_i),
    .res_i         (res_i)
  );

  // ---------------- environment: AGU, VRF memory and execute unit ----------
  function automatic logic [31:0] exec_fn(input logic [31:0] a, input logic [31:0] b);
    return (a + {b[15:0], b[31:16]}) ^ 32'h5a5a_3c3c;
  endfunction

  logic [31:0] vs1 [N];
  logic [31:0] vs2 [N];
  logic [31:0] vd  [N];
  int gnt_delay = 0, exec_lat = 0, rs2_base = 0;
  int wait_cnt = 0, exec_cnt = 0, rs1_ptr = 0, rs2_ptr = 0, rd_ptr = 0;
  logic        rvalid_q = 1'b0;
  logic [31:0] rdata_q = '0;
  logic        req_pend = 1'b0;
  int cyc = 0, done_cyc = 0;
  int n_rs1 = 0, n_rs2 = 0, n_wr = 0, n_incr = 0, n_done = 0, n_opv = 0, n_g1 = 0, n_viol = 0;

  assign mem_gnt_i    = mem_req_o && (wait_cnt >= gnt_delay);
  assign mem_rvalid_i = rvalid_q;
  assign mem_rdata_i  = rdata_q;
  assign res_valid_i  = op_valid_o && (exec_cnt >= exec_lat);
  assign res_i        = exec_fn(op_a_o, op_b_o);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= 0;
      exec_cnt <= 0;
      rvalid_q <= 1'b0;
      req_pend <= 1'b0;
    end else begin
      wait_cnt <= (mem_req_o && !mem_gnt_i) ? wait_cnt + 1 : 0;
      exec_cnt <= (op_valid_o && !res_valid_i) ? exec_cnt + 1 : 0;
      rvalid_q <= 1'b0;
      if (agu_load_o) begin
        rs1_ptr <= 0;
        rs2_ptr <= rs2_base;
        rd_ptr  <= 0;
      end
      if (mem_req_o && mem_gnt_i) begin
        rvalid_q <= 1'b1;  // also after writes: the sequencer must ignore it
        if (mem_we_o) begin
          vd[rd_ptr] <= mem_wdata_o;
          rdata_q    <= 32'hbad0_bad0;
          n_wr       <= n_wr + 1;
        end else if (agu_get_rs1_o) begin
          rdata_q <= vs1[rs1_ptr];
          n_rs1   <= n_rs1 + 1;
        end else begin
          rdata_q <= vs2[rs2_ptr];
          n_rs2   <= n_rs2 + 1;
        end
      end
      if (agu_incr_o) begin
        n_incr <= n_incr + 1;
        if (agu_get_rs1_o) rs1_ptr <= rs1_ptr + 1;
        if (agu_get_rs2_o) rs2_ptr <= rs2_ptr + 1;
        if (agu_get_rd_o)  rd_ptr  <= rd_ptr + 1;
      end
      if (done_o) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
      end
      if (op_valid_o)    n_opv <= n_opv + 1;
      if (agu_get_rs1_o) n_g1  <= n_g1 + 1;
      // Protocol rules: one source select at a time, increment only with a
      // granted request, and a pending request is held until granted.
      if ((int'(agu_get_rs1_o) + int'(agu_get_rs2_o) + int'(agu_get_rd_o)) > 1 ||
          agu_incr_o !== (mem_req_o && mem_gnt_i) || (req_pend && !mem_req_o))
        n_viol <= n_viol + 1;
      req_pend <= mem_req_o && !mem_gnt_i;
    end
  end

  // ---------------- checking ------------------------------------------------
  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [31:0] a_last = '0, b_last = '0;
  int start_cyc;
  int b_rs1, b_rs2, b_wr, b_incr, b_done, b_opv, b_g1, b_viol;

  // Issue one instruction and check it against the rule-level model.
  task automatic do_op(input logic u1, input logic u2, input logic sl, input int off,
                       input int g, input int lat, input int busy_at);
    int nw, per, exp_lat, e_rs1, e_rs2;
    bit timed_out;
    logic [31:0] exp;
    gnt_delay = g;
    exec_lat  = lat;
    rs2_base  = sl ? off : 0;
    for (int i = 0; i < N; i++) begin
      vs1[i] = $urandom;
      vs2[i] = $urandom;
    end
    b_rs1 = n_rs1; b_rs2 = n_rs2; b_wr = n_wr; b_incr = n_incr;
    b_done = n_done; b_opv = n_opv; b_g1 = n_g1; b_viol = n_viol;
    @(negedge clk);
    start_i = 1'b1; use_rs1_i = u1; use_rs2_i = u2;
`ifdef VCVE2_SLIDE_EN
    slide_i = sl; slide_up_i = 1'b0; slide_off_i = off[CW:0];
`endif
    start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0; use_rs1_i = 1'b0; use_rs2_i = 1'b0;
`ifdef VCVE2_SLIDE_EN
    slide_i = 1'b0; slide_off_i = '0;
`endif
    timed_out = 1'b1;
    for (int k = 1; k < 400; k++) begin
      if (n_done > b_done) begin
        timed_out = 1'b0;
        break;
      end
      start_i = (k == busy_at);
      @(negedge clk);
    end
    start_i = 1'b0;
    repeat (6) @(negedge clk);

    // Model: words processed, reads per source and cycles per word.
    nw    = sl ? ((off >= N) ? 0 : N - off) : N;
    e_rs1 = (u1 && !sl) ? N : 0;
    e_rs2 = (u2 || sl) ? nw : 0;
    if (sl) per = (2 + g) + (1 + g);
    else    per = (u1 ? 2 + g : 0) + (u2 ? 2 + g : 0) + (1 + lat) + (1 + g);
    exp_lat = 2 + nw * per;

    check("timeout", 64'(timed_out), 64'd0);
    check("latency", 64'(done_cyc - start_cyc), 64'(exp_lat));
    check("done_count", 64'(n_done - b_done), 64'd1);
    check("idle_after", 64'(busy_o), 64'd0);
    check("rs1_reads", 64'(n_rs1 - b_rs1), 64'(e_rs1));
    check("rs2_reads", 64'(n_rs2 - b_rs2), 64'(e_rs2));
    check("rd_writes", 64'(n_wr - b_wr), 64'(nw));
    check("incr_total", 64'(n_incr - b_incr), 64'(e_rs1 + e_rs2 + nw));
    check("op_valid_cycles", 64'(n_opv - b_opv), 64'(sl ? 0 : nw * (1 + lat)));
    check("rs1_get_cycles", 64'(n_g1 - b_g1), 64'(e_rs1 * (2 + g)));
    check("protocol", 64'(n_viol - b_viol), 64'd0);
    for (int i = 0; i < nw; i++) begin
      if (sl) exp = vs2[i + off];
      else    exp = exec_fn(u1 ? vs1[i] : a_last, u2 ? vs2[i] : b_last);
      check($sformatf("vd[%0d]", i), 64'(vd[i]), 64'(exp));
    end
    if (!sl && u1) a_last = vs1[N-1];
    if (!sl && u2) b_last = vs2[N-1];
    check("op_a_hold", 64'(op_a_o), 64'(a_last));
    check("op_b_hold", 64'(op_b_o), 64'(b_last));
  endtask

  function automatic logic [9:0] ctrl_bits();
    return {busy_o, done_o, agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o,
            agu_incr_o, mem_req_o, mem_we_o, op_valid_o};
  endfunction

  initial begin
    bit found;
    // Reset state.
    #1;
    check("reset_ctrl", 64'(ctrl_bits()), 64'd0);
    check("reset_data", {op_a_o, op_b_o} | 64'(mem_wdata_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_ctrl", 64'(ctrl_bits()), 64'd0);

    // Both operands, zero wait: 2 + 6*4 = 26 cycles.
    do_op(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
    // Grants delayed by 3 cycles on every request.
    do_op(1'b1, 1'b1, 1'b0, 0, 3, 0, 0);
    // vs2 only: 2 + 4*4 = 18 cycles, op_a keeps its last value.
    do_op(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    // start_i pulsed while busy is ignored.
    do_op(1'b1, 1'b1, 1'b0, 0, 0, 0, 5);

    // Asynchronous reset in RS2_WAIT of word 2.
    gnt_delay = 0;
    exec_lat  = 0;
    rs2_base  = 0;
    @(negedge clk);
    start_i = 1'b1; use_rs1_i = 1'b1; use_rs2_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; use_rs1_i = 1'b0; use_rs2_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (agu_get_rs2_o && !mem_req_o && rd_ptr == 2) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_point_reached", 64'(found), 64'd1);
    rst_i = 1'b1;
    #1;
    check("midrst_ctrl", 64'(ctrl_bits()), 64'd0);
    check("midrst_op_a", 64'(op_a_o), 64'd0);
    check("midrst_op_b", 64'(op_b_o), 64'd0);
    check("midrst_wdata", 64'(mem_wdata_o), 64'd0);
    a_last = '0;
    b_last = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    do_op(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);

    // Randomised operand selection, grant delay and execute latency.
    for (int r = 0; r < 4; r++)
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0,
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);

`ifdef VCVE2_SLIDE_EN
    do_op(1'b0, 1'b0, 1'b1, 1, 0, 0, 0);
    do_op(1'b1, 1'b1, 1'b1, 2, 1, 0, 0);
    do_op(1'b0, 1'b0, 1'b1, 4, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
